csi2_video_frame_gate: RTL and testbench

- Sits directly downstream of the CSI-2 receiver's pixel-clock video output. It consumes the AXI4-Stream pixel stream, where tuser marks start of frame (SOF) and tlast marks end of line (EOL).
- Gates the stream so only whole frames pass: enable/disable takes effect only on an SOF boundary.
- Measures frame width (pixels/line) and height (lines/frame) and flags line-length and truncated-frame errors.
- Output passes through a one-stage register slice.

---
 rtl/csi2_video_frame_gate_if.sv | 14 +
 rtl/csi2_video_frame_gate.sv | 154 +++++++++++++++
 tb/tb_csi2_video_frame_gate.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csi2_video_frame_gate_if.sv
// AXI4-Stream video bundle: tuser[0] marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/csi2_video_frame_gate.sv
// Whole-frame gate for CSI-2 pixel video with frame size measurement and error flags.
// state    | meaning
// WAIT_SOF | discard words until an SOF arrives with enable_i set
// PASS     | forward words until an SOF arrives with enable_i clear
module csi2_video_frame_gate #(
  parameter int TDATA_WIDTH = 16,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 enable_i,
  axi4_stream_if.slave         video_i,
  axi4_stream_if.master        video_o,
  output logic [CNT_WIDTH-1:0] frame_width_o,
  output logic [CNT_WIDTH-1:0] frame_height_o,
  output logic                 res_valid_o,
  output logic                 line_err_o,
  output logic                 frame_err_o
);

  typedef enum logic [0:0] {WAIT_SOF = 1'b0, PASS = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic [TDATA_WIDTH-1:0] out_data;
  logic                   out_user;
  logic                   out_last;
  logic                   out_valid;

  logic in_ready, accept, load, sof, out_free;

  logic [CNT_WIDTH-1:0] px_cnt, ln_cnt, first_len;
  logic [CNT_WIDTH-1:0] px_inc, ln_inc;
  logic                 first_seen, sof_seen;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign sof      = video_i.tuser[0];
  assign out_free = !out_valid || video_o.tready;
  assign accept   = video_i.tvalid && in_ready;
  assign px_inc   = sat_inc(px_cnt);
  assign ln_inc   = sat_inc(ln_cnt);

  assign video_i.tready  = in_ready;
  assign video_o.tdata   = out_data;
  assign video_o.tuser   = out_user;
  assign video_o.tlast   = out_last;
  assign video_o.tvalid  = out_valid;

  always_ff @(posedge clk_i) begin
    if (srst_i) state <= WAIT_SOF;
    else        state <= state_next;
  end

  // While discarding, only an enabled SOF needs the output slot; a word still
  // stalled there from the previous frame must not be overwritten.
  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    load       = 1'b0;
    case (state)
      WAIT_SOF: begin
        in_ready = out_free || !(sof && enable_i);
        if (video_i.tvalid && in_ready && sof && enable_i) begin
          load       = 1'b1;
          state_next = PASS;
        end
      end
      PASS: begin
        in_ready = out_free;
        if (video_i.tvalid && in_ready) begin
          if (sof && !enable_i) state_next = WAIT_SOF;
          else                  load       = 1'b1;
        end
      end
      default: state_next = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= video_i.tdata;
      out_user  <= sof;
      out_last  <= video_i.tlast;
    end else if (video_o.tready) begin
      out_valid <= 1'b0;
    end
  end

  // SOF boundary closes the old frame first; a tlast on the SOF word is then
  // treated as a complete 1-pixel line 0 of the new frame.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      px_cnt         <= '0;
      ln_cnt         <= '0;
      first_len      <= '0;
      first_seen     <= 1'b0;
      sof_seen       <= 1'b0;
      frame_width_o  <= '0;
      frame_height_o <= '0;
      res_valid_o    <= 1'b0;
      line_err_o     <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      line_err_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (accept) begin
        if (sof) begin
          if (sof_seen) begin
            frame_width_o  <= first_len;
            frame_height_o <= ln_cnt;
            res_valid_o    <= 1'b1;
            frame_err_o    <= (px_cnt != '0);
          end
          sof_seen <= 1'b1;
          if (video_i.tlast) begin
            first_len  <= CNT_ONE;
            first_seen <= 1'b1;
            ln_cnt     <= CNT_ONE;
            px_cnt     <= '0;
          end else begin
            first_len  <= '0;
            first_seen <= 1'b0;
            ln_cnt     <= '0;
            px_cnt     <= CNT_ONE;
          end
        end else if (video_i.tlast) begin
          px_cnt <= '0;
          ln_cnt <= ln_inc;
          if (!first_seen) begin
            first_len  <= px_inc;
            first_seen <= 1'b1;
          end else begin
            line_err_o <= sof_seen && (px_inc != first_len);
          end
        end else begin
          px_cnt <= px_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_csi2_video_frame_gate.sv
// Randomized scoreboard bench for csi2_video_frame_gate using a frame-level reference model.
module tb_csi2_video_frame_gate;

  localparam int DW = 16;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic srst;
  logic enable;
  logic [CW-1:0] frame_width, frame_height;
  logic res_valid, line_err, frame_err;

  axi4_stream_if #(.DATA_WIDTH(DW)) vin ();
  axi4_stream_if #(.DATA_WIDTH(DW)) vout ();

  csi2_video_frame_gate #(.TDATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .enable_i       (enable),
    .video_i        (vin),
    .video_o        (vout),
    .frame_width_o  (frame_width),
    .frame_height_o (frame_height),
    .res_valid_o    (res_valid),
    .line_err_o     (line_err),
    .frame_err_o    (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries are {tuser, tlast, tdata}
  int sb_q[$];

  // 0: always ready, 1: random 50%, 2: stalled
  int rdy_mode = 0;

  // Frame-level reference model state
  bit passing = 0;
  bit have_prev = 0;
  int prev_w = 0, prev_h = 0;
  bit prev_err = 0;
  int lens[16];
  int toggle_at = -1;
  bit toggle_val = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Output side: drives tready, pops and compares every transfer, checks hold and ready rules
  initial begin : monitor
    bit hold = 0;
    int held = 0;
    int word;
    vout.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: vout.tready = 1'b1;
        1: vout.tready = ($urandom_range(0, 1) == 1);
        default: vout.tready = 1'b0;
      endcase
      @(negedge clk);
      word = {vout.tuser[0], vout.tlast, vout.tdata};
      if (hold && vout.tvalid) chk("stall_hold", word, held);
      chk("in_ready_rule", int'(vin.tready || (vout.tvalid && !vout.tready)), 1);
      hold = vout.tvalid && !vout.tready;
      held = word;
      if (vout.tvalid && vout.tready) begin
        if (sb_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL out_word: unexpected word %0h with empty scoreboard", word);
        end else begin
          chk("out_word", word, sb_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    vin.tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("line_err_idle", int'(line_err), 0);
      chk("frame_err_idle", int'(frame_err), 0);
    end
  endtask

  task automatic send_word(input bit s, input bit e, input bit fwd, input bit le,
                           input bit fe, input bit meas);
    logic [DW-1:0] d;
    bit acc;
    int budget;
    d = DW'($urandom);
    if ($urandom_range(0, 3) == 0) idle(1);
    vin.tdata  = d;
    vin.tuser  = s;
    vin.tlast  = e;
    vin.tvalid = 1'b1;
    acc = 0;
    budget = 0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = vin.tready;
      if (acc && fwd) sb_q.push_back({s, e, d});
      @(posedge clk);
      #1;
      budget++;
      if (!acc) begin
        chk("line_err_wait", int'(line_err), 0);
        chk("frame_err_wait", int'(frame_err), 0);
      end
    end
    vin.tvalid = 1'b0;
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: word not accepted after %0d cycles", budget);
      return;
    end
    chk("line_err", int'(line_err), int'(le));
    chk("frame_err", int'(frame_err), int'(fe));
    if (meas) begin
      chk("frame_width", int'(frame_width), prev_w);
      chk("frame_height", int'(frame_height), prev_h);
      chk("res_valid", int'(res_valid), 1);
    end
    if (fwd && rdy_mode == 0) begin
      chk("latency_valid", int'(vout.tvalid), 1);
      chk("latency_word", int'({vout.tuser[0], vout.tlast, vout.tdata}), int'({s, e, d}));
    end
  endtask

  // Frame of n complete lines (lengths in lens[]) plus an optional truncated line
  task automatic send_frame(input int n, input int partial);
    int w = 0;
    bit s, e, le, fe, meas;
    for (int l = 0; l < n; l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        if (w == toggle_at) enable = toggle_val;
        s = (l == 0 && p == 0);
        e = (p == lens[l] - 1);
        if (s) passing = enable;
        meas = s && have_prev;
        fe = s && have_prev && prev_err;
        le = e && (l > 0) && (lens[l] != lens[0]);
        send_word(s, e, passing, le, fe, meas);
        w++;
      end
    end
    for (int p = 0; p < partial; p++) send_word(1'b0, 1'b0, passing, 1'b0, 1'b0, 1'b0);
    have_prev = 1;
    prev_w = lens[0];
    prev_h = n;
    prev_err = (partial != 0);
    toggle_at = -1;
  endtask

  task automatic set_lens(input int n, input int len);
    for (int i = 0; i < n; i++) lens[i] = len;
  endtask

  initial begin : driver
    int n, part;
    srst = 1'b1;
    enable = 1'b0;
    vin.tvalid = 1'b0;
    vin.tdata = '0;
    vin.tuser = '0;
    vin.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    chk("rst_tvalid", int'(vout.tvalid), 0);
    chk("rst_width", int'(frame_width), 0);
    chk("rst_height", int'(frame_height), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_line_err", int'(line_err), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_in_ready", int'(vin.tready), 1);

    // Three 4x6 frames, always ready
    enable = 1'b1;
    rdy_mode = 0;
    set_lens(4, 6);
    repeat (3) send_frame(4, 0);
    idle(3);

    // Disable at SOF then enable mid-frame; enabled frame then disabled mid-frame
    enable = 1'b0;
    toggle_at = 10; toggle_val = 1'b1;
    send_frame(4, 0);
    toggle_at = 5; toggle_val = 1'b0;
    send_frame(4, 0);
    send_frame(4, 0);
    idle(3);

    // Backpressure over two 8x5 frames
    enable = 1'b1;
    rdy_mode = 1;
    set_lens(8, 5);
    repeat (2) send_frame(8, 0);

    // Line length mismatch on the third line
    lens[0] = 6; lens[1] = 6; lens[2] = 5; lens[3] = 6;
    send_frame(4, 0);
    set_lens(4, 6);
    send_frame(4, 0);

    // Truncated frame: 2 lines then 3 pixels of line 2
    send_frame(2, 3);
    send_frame(4, 0);
    send_frame(3, 0);

    // Reset while a word is stalled at the output
    rdy_mode = 0;
    idle(5);
    rdy_mode = 2;
    idle(1);
    passing = 1'b1;
    send_word(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("stalled_valid", int'(vout.tvalid), 1);
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    sb_q.delete();
    passing = 1'b0;
    have_prev = 0;
    chk("srst_tvalid", int'(vout.tvalid), 0);
    chk("srst_width", int'(frame_width), 0);
    chk("srst_height", int'(frame_height), 0);
    chk("srst_res_valid", int'(res_valid), 0);
    chk("srst_line_err", int'(line_err), 0);
    chk("srst_frame_err", int'(frame_err), 0);
    rdy_mode = 0;
    for (int i = 0; i < 7; i++) send_word(1'b0, (i == 5), 1'b0, 1'b0, 1'b0, 1'b0);
    set_lens(3, 4);
    send_frame(3, 0);
    send_frame(3, 0);

    // Randomized frames with random enable, backpressure and 1-pixel lines
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 5);
      lens[0] = $urandom_range(1, 7);
      for (int l = 1; l < n; l++)
        lens[l] = ($urandom_range(0, 1) == 1) ? lens[0] : $urandom_range(1, 7);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        toggle_at = $urandom_range(1, 6);
        toggle_val = ~enable;
      end
      send_frame(n, part);
    end
    set_lens(2, 3);
    send_frame(2, 0);

    rdy_mode = 0;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) idle(1);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
